// File: rtl/my_pe_vec.sv
// my_pe_vec -- LANES-wide signed multiply-accumulate engine (vector dot product).
//
// A job starts with start in IDLE and runs cfg_len beats (0 means 2^L_RAM_SIZE).
// Each accepted beat multiplies ain_i*bin_i per lane (stage 1); the registered
// product is added to lane accumulator acc_i on the next edge (stage 2). Two
// DRAIN cycles let the last product land before the result is offered on
// m_valid/dout.
//
// Build option: define MY_PE_VEC_SAT_EN for saturating accumulation with a
// sticky per-lane ovf flag. Without it the accumulators wrap modulo
// 2^ACC_WIDTH and ovf is tied to 0.
//
// Ports:
//   aclk, areset         clock, async active-high reset
//   start, cfg_len       job start (IDLE only) and beat count
//   busy                 state != IDLE
//   s_valid/s_ready      operand beat handshake; ain/bin packed per lane
//   m_valid/m_ready      result handshake; dout packed per lane
//   ovf                  per-lane sticky saturation flag

module my_pe_vec_lane #(
  parameter int BITWIDTH  = 32,
  parameter int ACC_WIDTH = 72
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        clr,
  input  logic                        ld,
  input  logic                        add,
  input  logic signed [BITWIDTH-1:0]  a,
  input  logic signed [BITWIDTH-1:0]  b,
  output logic signed [ACC_WIDTH-1:0] acc,
  output logic                        ovf
);
  logic signed [2*BITWIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  prod_x;

  // signed size cast sign-extends the product to the accumulator width
  assign prod_x = ACC_WIDTH'(prod);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)  prod <= '0;
    else if (ld) prod <= a * b;
  end

`ifdef MY_PE_VEC_SAT_EN
  // one guard bit: overflow when the two top bits of the sum disagree
  logic signed [ACC_WIDTH:0] sum;
  assign sum = {acc[ACC_WIDTH-1], acc} + {prod_x[ACC_WIDTH-1], prod_x};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (add) begin
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
        acc <= sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                              : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        ovf <= 1'b1;
      end else begin
        acc <= sum[ACC_WIDTH-1:0];
      end
    end
  end
`else
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)   acc <= '0;
    else if (clr) acc <= '0;
    else if (add) acc <= acc + prod_x;
  end

  assign ovf = 1'b0;
`endif
endmodule

module my_pe_vec #(
  parameter int BITWIDTH   = 32,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 72,
  parameter int L_RAM_SIZE = 6
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         start,
  input  logic [L_RAM_SIZE-1:0]        cfg_len,
  output logic                         busy,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [LANES*BITWIDTH-1:0]    ain,
  input  logic [LANES*BITWIDTH-1:0]    bin,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [LANES*ACC_WIDTH-1:0]   dout,
  output logic [LANES-1:0]             ovf
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACC   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0]          state;
  logic [L_RAM_SIZE:0] rem;        // beats left; one extra bit holds 2^L_RAM_SIZE
  logic                drain_cnt;
  logic                clr;
  logic [1:0]          vld_pipe;   // [0] beat accepted now, [1] product registered

  assign s_ready     = (state == ACC);
  assign busy        = (state != IDLE);
  assign m_valid     = (state == OUT);
  assign clr         = (state == IDLE) && start;
  assign vld_pipe[0] = s_valid && s_ready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) vld_pipe[1] <= 1'b0;
    else        vld_pipe[1] <= vld_pipe[0];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      rem       <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          rem   <= (cfg_len == '0) ? {1'b1, {L_RAM_SIZE{1'b0}}} : {1'b0, cfg_len};
          state <= ACC;
        end
        ACC: if (vld_pipe[0]) begin
          rem <= rem - 1'b1;
          if (rem == (L_RAM_SIZE+1)'(1)) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          // cycle 1: last product registered -> added; cycle 2: result settled
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= OUT;
        end
        OUT: if (m_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    my_pe_vec_lane #(
      .BITWIDTH (BITWIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .aclk  (aclk),
      .areset(areset),
      .clr   (clr),
      .ld    (vld_pipe[0]),
      .add   (vld_pipe[1]),
      .a     (ain[i*BITWIDTH +: BITWIDTH]),
      .b     (bin[i*BITWIDTH +: BITWIDTH]),
      .acc   (dout[i*ACC_WIDTH +: ACC_WIDTH]),
      .ovf   (ovf[i])
    );
  end
endmodule

// File: doc/my_pe_vec.md
MY_PE_VEC -- requirements
Module: my_pe_vec

Interface
REQ-001 Parameter BITWIDTH, default 32: signed operand width per lane.
REQ-002 Parameter LANES, default 4: number of independent MAC lanes.
REQ-003 Parameter ACC_WIDTH, default 72: signed accumulator width per lane; SHALL be at least 2*BITWIDTH.
REQ-004 Parameter L_RAM_SIZE, default 6: log2 of maximum vector length.
REQ-005 Port aclk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-006 Port areset, input, 1: reset, asynchronous, active-high.
REQ-007 Port start, input, 1: begin a dot-product job.
REQ-008 Port cfg_len, input, L_RAM_SIZE: beats per job, sampled on accepted start; 0 means 2^L_RAM_SIZE.
REQ-009 Port busy, output, 1: high from accepted start until output handshake.
REQ-010 Port s_valid, input, 1: operand beat valid.
REQ-011 Port s_ready, output, 1: operand beat accepted when s_valid and s_ready are both high.
REQ-012 Port ain, input, LANES*BITWIDTH: lane i operand A in bits [i*BITWIDTH +: BITWIDTH].
REQ-013 Port bin, input, LANES*BITWIDTH: lane i operand B, same packing.
REQ-014 Port m_valid, output, 1: result valid.
REQ-015 Port m_ready, input, 1: downstream accepts result.
REQ-016 Port dout, output, LANES*ACC_WIDTH: lane i sum in bits [i*ACC_WIDTH +: ACC_WIDTH].
REQ-017 Port ovf, output, LANES: per-lane sticky saturation flag.

Function
REQ-018 FSM states IDLE, ACC, DRAIN, OUT; reset state IDLE.
REQ-019 IDLE: start=1 SHALL load the length counter from cfg_len, clear all accumulators and ovf, and go to ACC; start in any other state SHALL be ignored.
REQ-020 s_ready SHALL equal (state==ACC); beats offered in other states SHALL be ignored.
REQ-021 Each accepted beat SHALL register lane products ain_i*bin_i (stage 1); the next edge SHALL add the registered product to acc_i (stage 2).
REQ-022 Accepting the final beat SHALL move ACC to DRAIN; DRAIN SHALL last exactly 2 cycles, then enter OUT.
REQ-023 Latency: the final beat accepted at edge k SHALL give m_valid=1 and final dout at edge k+2.
REQ-024 Gaps (s_valid=0) within ACC SHALL not add anything nor advance the counter.
REQ-025 OUT: m_valid=1 and dout SHALL stay stable until m_valid and m_ready are both high; at that edge go to IDLE and m_valid=0.
REQ-026 dout SHALL be the accumulator registers; it SHALL hold its value after the handshake until the next accepted start.
REQ-027 Products SHALL be sign-extended to ACC_WIDTH before addition.
REQ-028 start and m_ready asserted in the same OUT cycle: the start SHALL be ignored; a new job needs start in IDLE.
REQ-029 busy SHALL equal (state!=IDLE).

Reset
REQ-030 areset=1 SHALL at once force IDLE, m_valid=0, busy=0, s_ready=0, dout=0, ovf=0, clear the pipeline and counter, and discard any job in progress.
REQ-031 After areset falls, the first start SHALL be accepted on the first rising edge of aclk.

Configuration
REQ-032 Macro MY_PE_VEC_SAT_EN defined: a lane add exceeding the signed ACC_WIDTH range SHALL clamp to the max or min value and set ovf[i] until the next start.
REQ-033 MY_PE_VEC_SAT_EN undefined: additions SHALL wrap modulo 2^ACC_WIDTH, and ovf SHALL be constant 0.

Verification
REQ-034 LANES=4, cfg_len=3, beats a=(1,2,3,4),(5,6,7,8),(-1,-1,-1,-1) each with b=(2,2,2,2) -> dout lanes (10,14,18,22), m_valid exactly 2 edges after the 3rd beat.
REQ-035 cfg_len=0, L_RAM_SIZE=6, 64 beats of a=1,b=1 on all lanes with s_valid toggling every cycle -> all lanes 64, s_ready low after the 64th beat.
REQ-036 Result ready with m_ready=0 for 5 cycles, then 1 -> dout stable for 6 cycles, one handshake, IDLE next cycle, start ignored while in OUT.
REQ-037 areset pulse after 2 of 4 beats -> outputs 0 at once; a new job of cfg_len=1, a=3, b=-4 then gives -12.
REQ-038 BITWIDTH=8, ACC_WIDTH=16, a=b=-128 for 4 beats: with MY_PE_VEC_SAT_EN -> 32767 and ovf=1; without it -> 0 (65536 mod 2^16) and ovf=0.
